// File: rtl/instr_fetch.sv
// Fetch stage: one word read per PC, returns PC+PC_STEP to the PC register, hands word+PC to decode.
// Latency 2 cycles IDLE->instr_valid on a first-cycle ack; decode stalls hold HOLD, redirects drop stale work.
module instr_fetch #(
   parameter logic [31:0] PC_STEP = 32'd4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [31:0] pc_rdata,
   output logic [31:0] pc_wdata,
   output logic        pc_wren,
   output logic [31:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        flush,
   output logic        fetch_err,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   state_t      state_q, state_d;
   logic [31:0] pc_wdata_q, pc_wdata_d;
   logic        pc_wren_q, pc_wren_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] instr_out_q, instr_out_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic        fetch_err_q, fetch_err_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic        discard_q, discard_d;
   logic [15:0] tmo_q, tmo_d;
   logic [15:0] tmo_inc;

   assign tmo_inc = tmo_q + 16'd1;

   // mem_addr_q doubles as the PC of the fetch in flight.
   always_comb begin
      state_d       = state_q;
      pc_wdata_d    = pc_wdata_q;
      pc_wren_d     = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_req_d     = mem_req_q;
      instr_out_d   = instr_out_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fetch_err_d   = fetch_err_q;
      fetch_count_d = fetch_count_q;
      discard_d     = discard_q;
      tmo_d         = tmo_q;
      case (state_q)
         IDLE: begin
            if (enable && !flush) begin
               mem_addr_d = pc_rdata;
               mem_req_d  = 1'b1;
               tmo_d      = 16'd0;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               tmo_d     = 16'd0;
               if (!discard_q && !flush) begin
                  instr_out_d   = mem_rdata;
                  instr_pc_d    = mem_addr_q;
                  instr_valid_d = 1'b1;
                  pc_wdata_d    = mem_addr_q + PC_STEP;
                  pc_wren_d     = 1'b1;
                  state_d       = HOLD;
               end else begin
                  discard_d = 1'b0;
                  state_d   = IDLE;
               end
            end else begin
               // A redirect cannot cancel the bus cycle; remember to drop its data instead.
               if (flush) discard_d = 1'b1;
               if (tmo_inc == TMO) begin
                  fetch_err_d = 1'b1;
                  mem_req_d   = 1'b0;
                  discard_d   = 1'b0;
                  state_d     = ERR;
               end else begin
                  tmo_d = tmo_inc;
               end
            end
         end
         HOLD: begin
            if (flush) begin
               instr_valid_d = 1'b0;
               state_d       = IDLE;
            end else if (instr_ready) begin
               instr_valid_d = 1'b0;
               fetch_count_d = fetch_count_q + 32'd1;
               state_d       = IDLE;
            end
         end
         default: begin
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_wdata_q    <= 32'd0;
         pc_wren_q     <= 1'b0;
         mem_addr_q    <= 32'd0;
         mem_req_q     <= 1'b0;
         instr_out_q   <= 32'd0;
         instr_pc_q    <= 32'd0;
         instr_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
         fetch_count_q <= 32'd0;
         discard_q     <= 1'b0;
         tmo_q         <= 16'd0;
      end else begin
         state_q       <= state_d;
         pc_wdata_q    <= pc_wdata_d;
         pc_wren_q     <= pc_wren_d;
         mem_addr_q    <= mem_addr_d;
         mem_req_q     <= mem_req_d;
         instr_out_q   <= instr_out_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fetch_err_q   <= fetch_err_d;
         fetch_count_q <= fetch_count_d;
         discard_q     <= discard_d;
         tmo_q         <= tmo_d;
      end
   end

   // The PC register favours this port, so the strobe must yield to a redirect or PC init.
   assign pc_wren     = pc_wren_q && !flush && enable;
   assign pc_wdata    = pc_wdata_q;
   assign mem_addr    = mem_addr_q;
   assign mem_req     = mem_req_q;
   assign instr_out   = instr_out_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign fetch_err   = fetch_err_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for plain fetches, hand sequences for redirect/stall/timeout/reset.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n, enable, mem_ack, instr_ready, flush;
   logic [31:0] pc_rdata, mem_rdata;
   logic [31:0] pc_wdata, mem_addr, instr_out, instr_pc, fetch_count;
   logic        pc_wren, mem_req, instr_valid, fetch_err;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   instr_fetch #(.PC_STEP(32'd4), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pc_rdata(pc_rdata),
      .pc_wdata(pc_wdata), .pc_wren(pc_wren), .mem_addr(mem_addr), .mem_req(mem_req),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_out(instr_out), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .flush(flush),
      .fetch_err(fetch_err), .fetch_count(fetch_count)
   );

   typedef struct {
      logic        rst_n, en;
      logic [31:0] pc;
      logic        ack;
      logic [31:0] rdata;
      logic        rdy, flush;
      logic        req;
      logic [31:0] addr;
      logic        wren;
      logic [31:0] wdata;
      logic        vld;
      logic [31:0] iout, ipc, cnt;
      logic        err;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //            rst en pc            ack rdata         rdy fl | req addr          wren wdata         vld iout          ipc           cnt    err
      vecs[0]  = '{0, 1, 32'h100,      0, 32'h0,        0, 0,   0, 32'h0,        0, 32'h0,   0, 32'h0,        32'h0,        32'd0, 0};
      vecs[1]  = '{1, 1, 32'h100,      0, 32'h0,        0, 0,   0, 32'h0,        0, 32'h0,   0, 32'h0,        32'h0,        32'd0, 0};
      vecs[2]  = '{1, 1, 32'h100,      0, 32'h0,        0, 0,   1, 32'h100,      0, 32'h0,   0, 32'h0,        32'h0,        32'd0, 0};
      vecs[3]  = '{1, 1, 32'h100,      1, 32'hDEADBEEF, 0, 0,   1, 32'h100,      0, 32'h0,   0, 32'h0,        32'h0,        32'd0, 0};
      vecs[4]  = '{1, 1, 32'h100,      0, 32'h0,        0, 0,   0, 32'h100,      1, 32'h104, 1, 32'hDEADBEEF, 32'h100,      32'd0, 0};
      vecs[5]  = '{1, 1, 32'h100,      0, 32'h0,        1, 0,   0, 32'h100,      0, 32'h104, 1, 32'hDEADBEEF, 32'h100,      32'd0, 0};
      vecs[6]  = '{1, 0, 32'h100,      0, 32'h0,        0, 0,   0, 32'h100,      0, 32'h104, 0, 32'hDEADBEEF, 32'h100,      32'd1, 0};
      vecs[7]  = '{1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 0,   0, 32'h100,      0, 32'h104, 0, 32'hDEADBEEF, 32'h100,      32'd1, 0};
      vecs[8]  = '{1, 1, 32'hFFFFFFFC, 1, 32'h12345678, 0, 0,   1, 32'hFFFFFFFC, 0, 32'h104, 0, 32'hDEADBEEF, 32'h100,      32'd1, 0};
      vecs[9]  = '{1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 0,   0, 32'hFFFFFFFC, 1, 32'h0,   1, 32'h12345678, 32'hFFFFFFFC, 32'd1, 0};
      vecs[10] = '{1, 0, 32'hFFFFFFFC, 0, 32'h0,        1, 0,   0, 32'hFFFFFFFC, 0, 32'h0,   1, 32'h12345678, 32'hFFFFFFFC, 32'd1, 0};

      rst_n = 1'b0; enable = 1'b0; pc_rdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      instr_ready = 1'b0; flush = 1'b0;
      repeat (2) tick();

      for (int i = 0; i < 11; i++) begin
         rst_n = vecs[i].rst_n; enable = vecs[i].en; pc_rdata = vecs[i].pc;
         mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
         instr_ready = vecs[i].rdy; flush = vecs[i].flush;
         #1;
         chk($sformatf("v%0d mem_req", i),     {31'd0, mem_req},     {31'd0, vecs[i].req});
         chk($sformatf("v%0d mem_addr", i),    mem_addr,             vecs[i].addr);
         chk($sformatf("v%0d pc_wren", i),     {31'd0, pc_wren},     {31'd0, vecs[i].wren});
         chk($sformatf("v%0d pc_wdata", i),    pc_wdata,             vecs[i].wdata);
         chk($sformatf("v%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].vld});
         chk($sformatf("v%0d instr_out", i),   instr_out,            vecs[i].iout);
         chk($sformatf("v%0d instr_pc", i),    instr_pc,             vecs[i].ipc);
         chk($sformatf("v%0d fetch_count", i), fetch_count,          vecs[i].cnt);
         chk($sformatf("v%0d fetch_err", i),   {31'd0, fetch_err},   {31'd0, vecs[i].err});
         tick();
      end

      // Redirect while the read is outstanding: request held to ack, data dropped.
      instr_ready = 1'b0; mem_ack = 1'b0; flush = 1'b0; enable = 1'b1; pc_rdata = 32'h200;
      tick();
      #1;
      chk("flush c1 mem_req", {31'd0, mem_req}, 32'd1);
      chk("flush c1 mem_addr", mem_addr, 32'h200);
      flush = 1'b1;
      #1;
      chk("flush c2 pc_wren", {31'd0, pc_wren}, 32'd0);
      tick();
      flush = 1'b0;
      for (int c = 3; c <= 4; c++) begin
         #1;
         chk($sformatf("flush c%0d mem_req", c), {31'd0, mem_req}, 32'd1);
         chk($sformatf("flush c%0d instr_valid", c), {31'd0, instr_valid}, 32'd0);
         tick();
      end
      mem_ack = 1'b1; mem_rdata = 32'hAAAA5555; pc_rdata = 32'h300;
      #1;
      chk("flush c5 mem_req", {31'd0, mem_req}, 32'd1);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("flush drop mem_req", {31'd0, mem_req}, 32'd0);
      chk("flush drop instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("flush drop pc_wren", {31'd0, pc_wren}, 32'd0);
      chk("flush drop instr_out", instr_out, 32'h12345678);
      chk("flush drop fetch_count", fetch_count, 32'd2);
      tick();
      #1;
      chk("refetch mem_addr", mem_addr, 32'h300);
      chk("refetch mem_req", {31'd0, mem_req}, 32'd1);

      // Decode stall, strobe suppressed while enable is low, then flush beats ready.
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack = 1'b0; enable = 1'b0;
      #1;
      chk("stall pc_wren gated", {31'd0, pc_wren}, 32'd0);
      chk("stall pc_wdata", pc_wdata, 32'h304);
      for (int c = 0; c < 10; c++) begin
         #1;
         chk($sformatf("stall%0d instr_valid", c), {31'd0, instr_valid}, 32'd1);
         chk($sformatf("stall%0d instr_out", c), instr_out, 32'hCAFEF00D);
         chk($sformatf("stall%0d instr_pc", c), instr_pc, 32'h300);
         tick();
      end
      flush = 1'b1; instr_ready = 1'b1;
      #1;
      tick();
      flush = 1'b0; instr_ready = 1'b0;
      #1;
      chk("flush+ready instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("flush+ready fetch_count", fetch_count, 32'd2);

      // flush in IDLE blocks the start, then a fetch that never gets an ack.
      enable = 1'b1; flush = 1'b1; pc_rdata = 32'h400;
      tick();
      #1;
      chk("idle flush mem_req", {31'd0, mem_req}, 32'd0);
      flush = 1'b0;
      tick();
      for (int c = 1; c <= 8; c++) begin
         #1;
         chk($sformatf("tmo c%0d mem_req", c), {31'd0, mem_req}, 32'd1);
         chk($sformatf("tmo c%0d fetch_err", c), {31'd0, fetch_err}, 32'd0);
         tick();
      end
      #1;
      chk("tmo mem_req", {31'd0, mem_req}, 32'd0);
      chk("tmo fetch_err", {31'd0, fetch_err}, 32'd1);
      mem_ack = 1'b1;
      repeat (3) tick();
      #1;
      chk("err sticky fetch_err", {31'd0, fetch_err}, 32'd1);
      chk("err sticky mem_req", {31'd0, mem_req}, 32'd0);
      chk("err sticky instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("err sticky pc_wren", {31'd0, pc_wren}, 32'd0);
      mem_ack = 1'b0; rst_n = 1'b0;
      tick();
      #1;
      chk("rst fetch_err", {31'd0, fetch_err}, 32'd0);
      chk("rst fetch_count", fetch_count, 32'd0);
      chk("rst instr_out", instr_out, 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);

      // Reset in the middle of a request; a late ack must be ignored.
      rst_n = 1'b1; enable = 1'b1; pc_rdata = 32'h500;
      tick();
      #1;
      chk("midrst mem_req before", {31'd0, mem_req}, 32'd1);
      chk("midrst mem_addr before", mem_addr, 32'h500);
      rst_n = 1'b0; enable = 1'b0;
      tick();
      #1;
      chk("midrst mem_req", {31'd0, mem_req}, 32'd0);
      chk("midrst mem_addr", mem_addr, 32'd0);
      rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h87654321;
      #1;
      tick();
      mem_ack = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("late ack%0d instr_valid", c), {31'd0, instr_valid}, 32'd0);
         chk($sformatf("late ack%0d pc_wren", c), {31'd0, pc_wren}, 32'd0);
         chk($sformatf("late ack%0d instr_out", c), instr_out, 32'd0);
         chk($sformatf("late ack%0d mem_req", c), {31'd0, mem_req}, 32'd0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
